// File: rtl/pfb_round_sat.sv
// pfb_round_sat: round / saturate stage for the PFB channelizer output path.
//
// Takes a wide signed accumulator word, adds a rounding constant chosen by
// rnd_mode, keeps bits [LSB_POS+OUT_WIDTH-1:LSB_POS] and either saturates or
// wraps on overflow. tuser/tlast travel with the data. The stream interface
// is a full AXI-stream handshake with backpressure.
//
// Pipeline: stage 1 (rounding add) -> stage 2 (slice / overflow / saturate)
// written into a 3-entry output queue. The queue head drives m_axis_*. The
// two entries behind it form the skid buffer, so s_axis_tready can be a
// register. Up to 4 beats can be in flight.
//
// Ports
//   clk, sync_reset           clock, synchronous active-high reset
//   rnd_mode[1:0]             0/3 truncate, 1 round-half-up, 2 convergent
//   sat_en                    1 saturate, 0 wrap on overflow
//   ovf_clr                   clears ovf_sticky (a same-cycle set wins)
//   s_axis_t{data,valid,user,last,ready}   input stream
//   m_axis_t{data,valid,user,last,ovf,ready} output stream
//   ovf_sticky                set by any overflowed beat presented at output
module pfb_round_sat #(
  parameter int unsigned IN_WIDTH   = 48,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned LSB_POS    = 24,
  parameter int unsigned USER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [1:0]            rnd_mode,
  input  logic                  sat_en,
  input  logic                  ovf_clr,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tovf,
  input  logic                  m_axis_tready,
  output logic                  ovf_sticky
);

  localparam int unsigned SUM_W    = IN_WIDTH + 1;
  localparam int unsigned MSB_KEEP = LSB_POS + OUT_WIDTH - 1;
  localparam int unsigned TOP_W    = IN_WIDTH - MSB_KEEP + 1;
  localparam int unsigned DEPTH    = 3;

  localparam logic [SUM_W-1:0]     RND_HALF = SUM_W'(1) << (LSB_POS - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Parameter sanity: need at least one fraction bit and the kept field inside the input.
  if (LSB_POS < 1 || LSB_POS + OUT_WIDTH > IN_WIDTH) begin : g_bad_params
    $error("pfb_round_sat: illegal LSB_POS/OUT_WIDTH/IN_WIDTH combination");
  end

  typedef struct packed {
    logic [OUT_WIDTH-1:0]  data;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
    logic                  ovf;
  } out_beat_t;

  // Stage 1 registers
  logic                  s1_vld;
  logic [SUM_W-1:0]      s1_sum;
  logic                  s1_sat;
  logic [USER_WIDTH-1:0] s1_user;
  logic                  s1_last;

  // Output queue (entry 0 is the presented beat) and input-ready register
  out_beat_t        q [DEPTH];
  out_beat_t        q_n [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_n;
  logic             s_ready_q;
  logic             sticky_q;

  // Combinational helpers
  logic [SUM_W-1:0] x_ext;
  logic [SUM_W-1:0] rnd_k;
  logic [SUM_W-1:0] sum_c;
  logic [TOP_W-1:0] s1_top;
  logic             s2_ovf;
  out_beat_t        s2_beat;
  logic             s_accept;
  logic             pop;
  logic             push;
  logic             placed;
  logic             s1_vld_n;
  logic             s_ready_n;

  // Rounding constant; convergent adds the kept LSB so exact ties land on even.
  always_comb begin
    rnd_k = '0;
    case (rnd_mode)
      2'd1:    rnd_k = RND_HALF;
      2'd2:    rnd_k = RND_HALF - SUM_W'(1) + SUM_W'(s_axis_tdata[LSB_POS]);
      default: rnd_k = '0;
    endcase
  end

  assign x_ext = {s_axis_tdata[IN_WIDTH-1], s_axis_tdata};
  assign sum_c = x_ext + rnd_k;

  // Overflow when the bits above the kept field disagree with its sign bit.
  assign s1_top = s1_sum[IN_WIDTH:MSB_KEEP];
  assign s2_ovf = (s1_top != '0) && (s1_top != '1);

  // Stage 2: slice, then saturate toward the sign of the full-precision sum.
  always_comb begin
    s2_beat.data = s1_sum[MSB_KEEP:LSB_POS];
    s2_beat.user = s1_user;
    s2_beat.last = s1_last;
    s2_beat.ovf  = s2_ovf;
    if (s2_ovf && s1_sat) begin
      s2_beat.data = s1_sum[IN_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  assign s_accept = s_axis_tvalid & s_ready_q;
  assign pop      = vld[0] & m_axis_tready;

  // Queue update: shift out the consumed head, then write stage 2 into the
  // first free slot. The head never changes while it is stalled.
  always_comb begin
    q_n    = q;
    vld_n  = vld;
    placed = 1'b0;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_n[i] = q[i+1];
      end
      vld_n = {1'b0, vld[DEPTH-1:1]};
    end
    push = s1_vld & ~vld_n[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !placed && !vld_n[i]) begin
        q_n[i]   = s2_beat;
        vld_n[i] = 1'b1;
        placed   = 1'b1;
      end
    end
  end

  // Ready for next cycle only if a new beat is guaranteed a slot even if the
  // output stalls: i.e. fewer than 4 beats will be in flight.
  assign s1_vld_n  = (s1_vld & ~push) | s_accept;
  assign s_ready_n = ~(s1_vld_n & vld_n[DEPTH-1]);

  // All pipeline state
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      s_ready_q <= 1'b0;
      s1_vld    <= 1'b0;
      s1_sum    <= '0;
      s1_sat    <= 1'b0;
      s1_user   <= '0;
      s1_last   <= 1'b0;
      vld       <= '0;
      sticky_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      s_ready_q <= s_ready_n;
      s1_vld    <= s1_vld_n;
      if (s_accept) begin
        s1_sum  <= sum_c;
        s1_sat  <= sat_en;
        s1_user <= s_axis_tuser;
        s1_last <= s_axis_tlast;
      end
      q   <= q_n;
      vld <= vld_n;
      // Set has priority over clear.
      if (vld[0] && q[0].ovf) begin
        sticky_q <= 1'b1;
      end else if (ovf_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = vld[0];
  assign m_axis_tdata  = q[0].data;
  assign m_axis_tuser  = q[0].user;
  assign m_axis_tlast  = q[0].last;
  assign m_axis_tovf   = q[0].ovf;
  assign ovf_sticky    = sticky_q;

endmodule
